// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer.
// Holds the command opcode encodings, the controller state encodings and
// the s1/s0 mode-select constants driven into the universal shift register.
// No ports; imported by the interface, the datapath and the controller.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // {s1, s0} mode select for the universal shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // True for the two opcodes that consume a shift count
    function automatic logic op_is_shift(input op_t op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command channel between a host front end and the shift-register sequencer.
// Signals:
//   cmd_valid  host has a command
//   cmd_ready  sequencer can take a command this cycle
//   cmd_op     opcode (NOP / shift right / shift left / load)
//   cmd_rot    1 = rotate, 0 = fill from serial_in
//   cmd_count  number of shift cycles
//   cmd_data   parallel load value
// Modports: master (host side), slave (sequencer side).
interface shift_reg_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic             cmd_rot;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rot, cmd_count, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rot, cmd_count, cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/universal_shift_reg_sync.sv
// WIDTH-bit universal shift register with synchronous active-high clear.
// Ports:
//   CLK     clock, rising edge
//   Clear   synchronous clear, wins over every mode
//   s1, s0  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   MSB_in  bit entering the MSB on a right shift
//   LSB_in  bit entering the LSB on a left shift
//   I_par   parallel load value
//   A_par   register contents
module universal_shift_reg_sync
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             s1,
    input  logic             s0,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic [WIDTH-1:0] I_par,
    output logic [WIDTH-1:0] A_par
);

    always_ff @(posedge CLK) begin
        if (Clear) begin
            A_par <= '0;
        end else begin
            case ({s1, s0})
                MODE_SHR:  A_par <= {MSB_in, A_par[WIDTH-1:1]};
                MODE_SHL:  A_par <= {A_par[WIDTH-2:0], LSB_in};
                MODE_LOAD: A_par <= I_par;
                default:   A_par <= A_par;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for a universal shift register.
// Takes one command at a time over a valid/ready channel, drives the
// register's mode select for the required number of cycles and then pulses
// done for one cycle. Callers never touch the mode pins directly.
// Ports:
//   CLK        clock, rising edge
//   Clear      synchronous active-high reset, abandons any command in flight
//   cmd        command channel (slave side)
//   serial_in  fill bit for non-rotating shifts
//   A_par      register contents
//   busy       command in progress
//   done       one-cycle completion pulse, A_par holds the final value
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  CLK,
    input  logic                  Clear,
    shift_reg_sequencer_if.slave  cmd,
    input  logic                  serial_in,
    output logic [WIDTH-1:0]      A_par,
    output logic                  busy,
    output logic                  done
);

    state_t           state;
    state_t           state_next;
    op_t              op_q;
    logic             rot_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       mode;
    logic             ready;
    logic             accept;
    logic             msb_in;
    logic             lsb_in;

    assign accept        = cmd.cmd_valid && ready;
    assign cmd.cmd_ready = ready;
    assign busy          = ~ready;

    // State register
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch and shift down-counter; fields only need to be valid
    // in the accept cycle, so everything the EXEC phase uses is held here.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            op_q   <= OP_NOP;
            rot_q  <= 1'b0;
            cnt_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= cmd.cmd_op;
            rot_q  <= cmd.cmd_rot;
            cnt_q  <= cmd.cmd_count;
            data_q <= cmd.cmd_data;
        end else if (state == ST_EXEC && op_is_shift(op_q) && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Next state and mode decode; NOP and zero-count shifts skip EXEC so
    // the register is never touched for them.
    always_comb begin
        state_next = state;
        mode       = MODE_HOLD;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op == OP_NOP ||
                        (op_is_shift(cmd.cmd_op) && cmd.cmd_count == '0)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        mode       = MODE_LOAD;
                        state_next = ST_DONE;
                    end
                    OP_SHR, OP_SHL: begin
                        mode = (op_q == OP_SHR) ? MODE_SHR : MODE_SHL;
                        if (cnt_q == CNT_W'(1)) begin
                            state_next = ST_DONE;
                        end
                    end
                    default: state_next = ST_DONE;
                endcase
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Fill-bit mux: rotation feeds the bit falling off the opposite end
    always_comb begin
        msb_in = 1'b0;
        lsb_in = 1'b0;
        if (state == ST_EXEC) begin
            msb_in = rot_q ? A_par[0]       : serial_in;
            lsb_in = rot_q ? A_par[WIDTH-1] : serial_in;
        end
    end

    universal_shift_reg_sync #(
        .WIDTH (WIDTH)
    ) u_reg (
        .CLK    (CLK),
        .Clear  (Clear),
        .s1     (mode[1]),
        .s0     (mode[0]),
        .MSB_in (msb_in),
        .LSB_in (lsb_in),
        .I_par  (data_q),
        .A_par  (A_par)
    );

endmodule
